// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU opcodes, MIPS opcode/funct
// encodings, the decoded-entry record and the bypass match helper.
package alu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [3:0] ALUC_AND  = 4'b0000;
    localparam logic [3:0] ALUC_OR   = 4'b0001;
    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_XOR  = 4'b0011;
    localparam logic [3:0] ALUC_SLLV = 4'b0100;
    localparam logic [3:0] ALUC_SRLV = 4'b0101;
    localparam logic [3:0] ALUC_SUB  = 4'b0110;
    localparam logic [3:0] ALUC_NEG  = 4'b0111;
    localparam logic [3:0] ALUC_SLL  = 4'b1000;
    localparam logic [3:0] ALUC_SRL  = 4'b1001;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;

    // One decoded instruction as it sits in the issue register. The source
    // indices and t_is_reg are kept so a held entry can still be bypassed.
    typedef struct packed {
        logic [3:0]            aluc;
        logic [DATA_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] t;
        logic [4:0]            shamt;
        logic [4:0]            dest;
        logic [4:0]            rs_idx;
        logic [4:0]            rt_idx;
        logic                  t_is_reg;
        logic                  illegal;
    } entry_t;

    // Register 0 is hard-wired to zero, so it can never be a bypass target.
    function automatic logic bypass_hit(input logic       fwd_valid,
                                        input logic [4:0] fwd_reg,
                                        input logic [4:0] src);
        return fwd_valid && (fwd_reg != 5'd0) && (fwd_reg == src);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decoder: turns a MIPS R/I-type word plus its register-file
// operands into an ALU issue entry. Unsupported encodings are flagged illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output entry_t                entry
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    // Select ALU opcode, operand sources and destination from op/funct.
    always_comb begin
        entry          = '0;
        entry.s        = rs_data;
        entry.t        = rt_data;
        entry.rs_idx   = instr[25:21];
        entry.rt_idx   = instr[20:16];
        entry.t_is_reg = 1'b1;
        entry.illegal  = 1'b0;
        case (op)
            OP_RTYPE: begin
                entry.dest = instr[15:11];
                case (funct)
                    FN_AND:          entry.aluc = ALUC_AND;
                    FN_OR:           entry.aluc = ALUC_OR;
                    FN_ADD, FN_ADDU: entry.aluc = ALUC_ADD;
                    FN_XOR:          entry.aluc = ALUC_XOR;
                    FN_SLLV:         entry.aluc = ALUC_SLLV;
                    FN_SRLV:         entry.aluc = ALUC_SRLV;
                    FN_SUB, FN_SUBU: entry.aluc = ALUC_SUB;
                    FN_SLL: begin
                        entry.aluc  = ALUC_SLL;
                        entry.shamt = instr[10:6];
                    end
                    FN_SRL: begin
                        entry.aluc  = ALUC_SRL;
                        entry.shamt = instr[10:6];
                    end
                    default:         entry.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                entry.aluc     = ALUC_ADD;
                entry.t        = {{(DATA_WIDTH-16){imm[15]}}, imm};
                entry.t_is_reg = 1'b0;
                entry.dest     = instr[20:16];
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                entry.aluc     = (op == OP_ANDI) ? ALUC_AND :
                                 (op == OP_ORI)  ? ALUC_OR  : ALUC_XOR;
                entry.t        = {{(DATA_WIDTH-16){1'b0}}, imm};
                entry.t_is_reg = 1'b0;
                entry.dest     = instr[20:16];
            end
            default: entry.illegal = 1'b1;
        endcase
        if (entry.illegal) begin
            entry.aluc  = ALUC_AND;
            entry.dest  = 5'd0;
            entry.shamt = 5'd0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register in front of the ALU: valid/ready handshake on both
// sides, flush, and a single result bypass applied at capture and while held.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int BUS_WIDTH = DATA_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    input  logic [31:0]          instr_in,
    input  logic [BUS_WIDTH-1:0] rs_data_in,
    input  logic [BUS_WIDTH-1:0] rt_data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 flush_in,
    input  logic                 fwd_valid_in,
    input  logic [4:0]           fwd_reg_in,
    input  logic [BUS_WIDTH-1:0] fwd_data_in,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [3:0]           alucontrol_out,
    output logic [BUS_WIDTH-1:0] s_out,
    output logic [BUS_WIDTH-1:0] t_out,
    output logic [4:0]           shamt_out,
    output logic [4:0]           dest_reg_out,
    output logic                 illegal_out
);

    entry_t dec;
    entry_t cap;
    entry_t held;
    logic   valid_q;
    logic   accept;

    assign ready_out = !valid_q || ready_in;
    assign accept    = valid_in && ready_out && !flush_in;

    alu_decode u_decode (
        .instr   (instr_in),
        .rs_data (rs_data_in),
        .rt_data (rt_data_in),
        .entry   (dec)
    );

    // Apply the bypass to the freshly decoded entry; immediates are never replaced.
    always_comb begin
        cap = dec;
        if (bypass_hit(fwd_valid_in, fwd_reg_in, dec.rs_idx)) begin
            cap.s = fwd_data_in;
        end
        if (dec.t_is_reg && bypass_hit(fwd_valid_in, fwd_reg_in, dec.rt_idx)) begin
            cap.t = fwd_data_in;
        end
    end

    // Issue register: flush beats accept beats hold; a stalled entry keeps absorbing bypasses.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            valid_q <= 1'b0;
            held    <= '0;
        end else if (flush_in) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            held    <= cap;
        end else if (ready_in) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            if (bypass_hit(fwd_valid_in, fwd_reg_in, held.rs_idx)) begin
                held.s <= fwd_data_in;
            end
            if (held.t_is_reg && bypass_hit(fwd_valid_in, fwd_reg_in, held.rt_idx)) begin
                held.t <= fwd_data_in;
            end
        end
    end

    assign valid_out      = valid_q;
    assign alucontrol_out = held.aluc;
    assign s_out          = held.s;
    assign t_out          = held.t;
    assign shamt_out      = held.shamt;
    assign dest_reg_out   = held.dest;
    assign illegal_out    = held.illegal;

endmodule
